// File: rtl/render_pkg.sv
// Shared render-pipeline types: ray-march FSM states, result status codes and 3-component vectors.
package render_pkg;

    localparam int VEC_W = 16;

    typedef logic [3*VEC_W-1:0] vec3_t;

    typedef enum logic [1:0] {
        HIT     = 2'd0,
        MISS    = 2'd1,
        TIMEOUT = 2'd2
    } march_status_t;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP_REQ,
        LOOKUP_WAIT,
        STEP_START,
        STEP_WAIT,
        RESULT
    } march_state_t;

endpackage

// File: rtl/ray_marcher.sv
// Ray-march controller: alternates voxel lookups and AABB stepper calls until a hit,
// a world exit or the step budget ends the ray; every output is a register.
module ray_marcher
    import render_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int MAX_STEPS = 64,
    parameter int MAT_W     = 8
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             ray_valid,
    output logic                             ray_ready,
    input  logic [3*WIDTH-1:0]               ray_q,
    input  logic [3*WIDTH-1:0]               ray_v,
    output logic                             lookup_valid,
    input  logic                             lookup_ready,
    output logic [3*WIDTH-1:0]               lookup_pos,
    input  logic                             resp_valid,
    input  logic                             resp_occupied,
    input  logic [MAT_W-1:0]                 resp_material,
    input  logic [3*WIDTH-1:0]               resp_l,
    input  logic [3*WIDTH-1:0]               resp_u,
    output logic                             step_start,
    output logic [3*WIDTH-1:0]               step_q,
    output logic [3*WIDTH-1:0]               step_v,
    output logic [3*WIDTH-1:0]               step_l,
    output logic [3*WIDTH-1:0]               step_u,
    input  logic                             step_done,
    input  logic                             step_oob,
    input  logic [3*WIDTH-1:0]               step_qp,
    output logic                             result_valid,
    input  logic                             result_ready,
    output logic [1:0]                       result_status,
    output logic [3*WIDTH-1:0]               result_pos,
    output logic [MAT_W-1:0]                 result_material,
    output logic [$clog2(MAX_STEPS+1)-1:0]   result_steps
);

    localparam int CNT_W = $clog2(MAX_STEPS + 1);

    march_state_t        state;
    logic [3*WIDTH-1:0]  pos;
    logic [3*WIDTH-1:0]  dir;
    logic [CNT_W-1:0]    count;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_W'(MAX_STEPS)) ? c : c + 1'b1;
    endfunction

    always_ff @(posedge clock) begin
        if (!reset) begin
            state           <= IDLE;
            count           <= '0;
            ray_ready       <= 1'b0;
            lookup_valid    <= 1'b0;
            lookup_pos      <= '0;
            step_start      <= 1'b0;
            step_q          <= '0;
            step_v          <= '0;
            step_l          <= '0;
            step_u          <= '0;
            result_valid    <= 1'b0;
            result_status   <= '0;
            result_pos      <= '0;
            result_material <= '0;
            result_steps    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    ray_ready <= 1'b1;
                    if (ray_valid && ray_ready) begin
                        pos          <= ray_q;
                        dir          <= ray_v;
                        count        <= '0;
                        ray_ready    <= 1'b0;
                        lookup_valid <= 1'b1;
                        lookup_pos   <= ray_q;
                        state        <= LOOKUP_REQ;
                    end
                end
                LOOKUP_REQ: begin
                    if (lookup_ready) begin
                        lookup_valid <= 1'b0;
                        state        <= LOOKUP_WAIT;
                    end
                end
                // Responses are only consumed here, so stale ones arriving elsewhere are dropped.
                LOOKUP_WAIT: begin
                    if (resp_valid) begin
                        if (resp_occupied) begin
                            result_status   <= HIT;
                            result_material <= resp_material;
                            result_pos      <= pos;
                            result_steps    <= count;
                            result_valid    <= 1'b1;
                            state           <= RESULT;
                        end else if (count == CNT_W'(MAX_STEPS)) begin
                            result_status   <= TIMEOUT;
                            result_material <= '0;
                            result_pos      <= pos;
                            result_steps    <= count;
                            result_valid    <= 1'b1;
                            state           <= RESULT;
                        end else begin
                            step_l     <= resp_l;
                            step_u     <= resp_u;
                            step_q     <= pos;
                            step_v     <= dir;
                            step_start <= 1'b1;
                            state      <= STEP_START;
                        end
                    end
                end
                STEP_START: begin
                    step_start <= 1'b0;
                    count      <= sat_inc(count);
                    state      <= STEP_WAIT;
                end
                STEP_WAIT: begin
                    if (step_done) begin
                        if (step_oob) begin
                            result_status   <= MISS;
                            result_material <= '0;
                            result_pos      <= pos;
                            result_steps    <= count;
                            result_valid    <= 1'b1;
                            state           <= RESULT;
                        end else begin
                            pos          <= step_qp;
                            lookup_pos   <= step_qp;
                            lookup_valid <= 1'b1;
                            state        <= LOOKUP_REQ;
                        end
                    end
                end
                RESULT: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        ray_ready    <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
